// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared types and defaults for the dpram access controller
package dpram_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 2;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_CLR  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with a priority pointer
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       ena,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    // The pointer only moves on a contended grant; a sole grant leaves it alone.
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (ena) begin
            if (req == 2'b11) begin
                gnt   = ptr_q ? 2'b10 : 2'b01;
                ptr_d = ~ptr_q;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dpram_ctl.sv
// rtl/dpram_ctl.sv - dpram port A clear sequencer and two-requester arbiter
module dpram_ctl
    import dpram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ena_i,
    input  logic          clr_i,
    output logic          busy_o,
    input  logic          r0_stb_i,
    input  logic          r1_stb_i,
    input  logic          r0_we_i,
    input  logic          r1_we_i,
    input  logic [AW-1:0] r0_adr_i,
    input  logic [AW-1:0] r1_adr_i,
    input  logic [DW-1:0] r0_dat_i,
    input  logic [DW-1:0] r1_dat_i,
    output logic          r0_ack_o,
    output logic          r1_ack_o,
    output logic [DW-1:0] r0_dat_o,
    output logic [DW-1:0] r1_dat_o,
    output logic [AW-1:0] ram_adr_o,
    output logic [DW-1:0] ram_dat_o,
    output logic          ram_wre_o,
    input  logic [DW-1:0] ram_dat_i
);

    localparam logic [AW-1:0] CNT_LAST = '1;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          r0_ack_q, r0_ack_d;
    logic          r1_ack_q, r1_ack_d;
    logic [DW-1:0] r0_dat_q, r0_dat_d;
    logic [DW-1:0] r1_dat_q, r1_dat_d;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          wre;

    // The ~ack term keeps a requester from being re-granted while its ack is out.
    assign req = {r1_stb_i & ~r1_ack_q, r0_stb_i & ~r0_ack_q}
               & {2{state_q == ST_RUN}};

    rr_arb2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req   (req),
        .ena   (ena_i),
        .gnt   (gnt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_adr_o = r0_adr_i;
        ram_dat_o = r0_dat_i;
        wre       = 1'b0;
        unique case (state_q)
            ST_INIT, ST_CLR: begin
                ram_adr_o = cnt_q;
                ram_dat_o = '0;
                if (ena_i) begin
                    wre   = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (gnt[1]) begin
                    ram_adr_o = r1_adr_i;
                    ram_dat_o = r1_dat_i;
                    wre       = r1_we_i;
                end else if (gnt[0]) begin
                    wre = r0_we_i;
                end
                if (ena_i && clr_i) begin
                    state_d = ST_CLR;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        r0_ack_d = gnt[0];
        r1_ack_d = gnt[1];
        r0_dat_d = gnt[0] ? ram_dat_i : r0_dat_q;
        r1_dat_d = gnt[1] ? ram_dat_i : r1_dat_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            r0_ack_q <= 1'b0;
            r1_ack_q <= 1'b0;
            r0_dat_q <= '0;
            r1_dat_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r0_ack_q <= r0_ack_d;
            r1_ack_q <= r1_ack_d;
            r0_dat_q <= r0_dat_d;
            r1_dat_q <= r1_dat_d;
        end
    end

    // An INIT write must not reach the RAM while reset is still held.
    assign ram_wre_o = wre & ~rst_i;
    assign busy_o    = (state_q != ST_RUN);
    assign r0_ack_o  = r0_ack_q;
    assign r1_ack_o  = r1_ack_q;
    assign r0_dat_o  = r0_dat_q;
    assign r1_dat_o  = r1_dat_q;

endmodule

// File: tb/tb_dpram_ctl.sv
// tb/tb_dpram_ctl.sv - directed scoreboard bench for dpram_ctl
module tb_dpram_ctl;

    logic       clk, rst, ena, clr;
    logic       busy;
    logic       r0_stb, r1_stb, r0_we, r1_we;
    logic [4:0] r0_adr, r1_adr;
    logic [1:0] r0_wd, r1_wd;
    logic       r0_ack, r1_ack;
    logic [1:0] r0_rd, r1_rd;
    logic [4:0] ram_adr;
    logic [1:0] ram_wd;
    logic       ram_wre;
    logic [1:0] ram_rd;

    logic [1:0] mem [0:31] = '{default: 2'b10};
    int         wr_cnt = 0;

    typedef struct packed {
        logic       who;
        logic [1:0] dat;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    dpram_ctl u_dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .ena_i     (ena),
        .clr_i     (clr),
        .busy_o    (busy),
        .r0_stb_i  (r0_stb),
        .r1_stb_i  (r1_stb),
        .r0_we_i   (r0_we),
        .r1_we_i   (r1_we),
        .r0_adr_i  (r0_adr),
        .r1_adr_i  (r1_adr),
        .r0_dat_i  (r0_wd),
        .r1_dat_i  (r1_wd),
        .r0_ack_o  (r0_ack),
        .r1_ack_o  (r1_ack),
        .r0_dat_o  (r0_rd),
        .r1_dat_o  (r1_rd),
        .ram_adr_o (ram_adr),
        .ram_dat_o (ram_wd),
        .ram_wre_o (ram_wre),
        .ram_dat_i (ram_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_rd = mem[ram_adr];
    always @(posedge clk) begin
        if (ena && ram_wre) begin
            mem[ram_adr] <= ram_wd;
            wr_cnt       <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (r0_ack || r1_ack) begin
                chk("dual_ack", int'(r0_ack & r1_ack), 0);
                chk("sb_has_entry", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("ack_who", int'(r1_ack), int'(e.who));
                    chk("ack_dat", int'(r1_ack ? r1_rd : r0_rd), int'(e.dat));
                end
            end
        end
    end

    function automatic exp_t mk(input logic who, input logic [1:0] dat);
        exp_t e;
        e.who = who;
        e.dat = dat;
        return e;
    endfunction

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    task automatic acc(input int who, input logic we, input logic [4:0] adr,
                       input logic [1:0] dat, input logic [1:0] old);
        int lat;
        sb.push_back(mk(who[0], old));
        if (who == 0) begin
            r0_we = we; r0_adr = adr; r0_wd = dat; r0_stb = 1'b1;
        end else begin
            r1_we = we; r1_adr = adr; r1_wd = dat; r1_stb = 1'b1;
        end
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            lat = i;
            if ((who == 0) ? r0_ack : r1_ack) break;
        end
        chk("access_latency", lat, 1);
        r0_stb = 1'b0;
        r1_stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_both(input logic we0, input logic [4:0] a0, input logic [1:0] d0,
                            input logic we1, input logic [4:0] a1, input logic [1:0] d1,
                            input int n);
        int got;
        r0_we = we0; r0_adr = a0; r0_wd = d0; r0_stb = 1'b1;
        r1_we = we1; r1_adr = a1; r1_wd = d1; r1_stb = 1'b1;
        got = 0;
        for (int i = 0; i < 4 * n + 10; i++) begin
            @(negedge clk);
            if (r0_ack || r1_ack) got++;
            if (got == n) break;
        end
        chk("both_ack_count", got, n);
        r0_stb = 1'b0;
        r1_stb = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n, base, nz;
        logic early;
        rst = 1'b1; ena = 1'b1; clr = 1'b0;
        r0_stb = 1'b0; r1_stb = 1'b0; r0_we = 1'b0; r1_we = 1'b0;
        r0_adr = '0; r1_adr = '0; r0_wd = '0; r1_wd = '0;

        // Reset state and INIT
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 1);
        chk("rst_wre", int'(ram_wre), 0);
        chk("rst_acks", int'({r1_ack, r0_ack}), 0);
        chk("rst_dat", int'({r1_rd, r0_rd}), 0);
        @(posedge clk); #1 rst = 1'b0;
        base = wr_cnt;
        count_busy(n);
        chk("init_busy_cycles", n, 32);
        chk("init_writes", wr_cnt - base, 32);
        nz = 0;
        for (int a = 0; a < 32; a++) if (mem[a] !== 2'b00) nz++;
        chk("init_zeroed", nz, 0);

        // Single requester
        acc(0, 1'b1, 5'd5, 2'b11, 2'b00);
        acc(0, 1'b0, 5'd5, 2'b00, 2'b11);

        // Contention for 8 cycles, then a fresh contention checks the pointer
        for (int k = 0; k < 4; k++) begin
            sb.push_back(mk(1'b0, (k == 0) ? 2'b00 : 2'b01));
            sb.push_back(mk(1'b1, (k == 0) ? 2'b00 : 2'b10));
        end
        run_both(1'b1, 5'd8, 2'b01, 1'b1, 5'd9, 2'b10, 8);
        chk("cont_mem8", int'(mem[8]), 1);
        chk("cont_mem9", int'(mem[9]), 2);
        sb.push_back(mk(1'b1, 2'b10));
        sb.push_back(mk(1'b0, 2'b01));
        run_both(1'b1, 5'd8, 2'b01, 1'b1, 5'd9, 2'b10, 2);

        // Enable stall during INIT at cnt=10
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        base = wr_cnt;
        repeat (11) @(negedge clk);
        chk("stall_cnt_at", int'(ram_adr), 10);
        ena = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_init_wre", int'(ram_wre), 0);
            chk("stall_init_busy", int'(busy), 1);
            chk("stall_init_cnt", int'(ram_adr), 10);
            @(negedge clk);
        end
        ena = 1'b1;
        count_busy(n);
        chk("stall_init_rest", n, 21);
        chk("stall_init_writes", wr_cnt - base, 32);

        // Enable stall with both requests pending
        ena = 1'b0;
        r0_we = 1'b1; r0_adr = 5'd3; r0_wd = 2'b01; r0_stb = 1'b1;
        r1_we = 1'b1; r1_adr = 5'd4; r1_wd = 2'b10; r1_stb = 1'b1;
        base = wr_cnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_req_acks", int'({r1_ack, r0_ack}), 0);
            chk("stall_req_wre", int'(ram_wre), 0);
        end
        chk("stall_req_writes", wr_cnt - base, 0);
        ena = 1'b1;
        sb.push_back(mk(1'b0, 2'b00));
        sb.push_back(mk(1'b1, 2'b00));
        run_both(1'b1, 5'd3, 2'b01, 1'b1, 5'd4, 2'b10, 2);

        // Clear collides with an r1 write; r0 waits out the clear
        clr = 1'b1;
        r1_we = 1'b1; r1_adr = 5'd6; r1_wd = 2'b11; r1_stb = 1'b1;
        sb.push_back(mk(1'b1, 2'b00));
        @(negedge clk);
        chk("coll_r1_ack", int'(r1_ack), 1);
        chk("coll_busy", int'(busy), 1);
        clr = 1'b0; r1_stb = 1'b0;
        r0_we = 1'b0; r0_adr = 5'd6; r0_stb = 1'b1;
        sb.push_back(mk(1'b0, 2'b00));
        n = 1; early = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            early = early | r0_ack;
        end
        chk("clr_busy_cycles", n, 32);
        chk("clr_r0_held", int'(early), 0);
        chk("clr_r0_ack_at_fall", int'(r0_ack), 0);
        @(negedge clk);
        chk("clr_r0_ack_after", int'(r0_ack), 1);
        r0_stb = 1'b0;
        @(negedge clk);

        // Reset at cnt=17 during CLR
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (17) @(negedge clk);
        chk("mid_clr_cnt", int'(ram_adr), 17);
        rst = 1'b1;
        #1;
        chk("mid_clr_busy", int'(busy), 1);
        chk("mid_clr_wre", int'(ram_wre), 0);
        @(posedge clk); #1 rst = 1'b0;
        base = wr_cnt;
        #1;
        chk("mid_clr_restart_adr", int'(ram_adr), 0);
        chk("mid_clr_restart_wre", int'(ram_wre), 1);
        count_busy(n);
        chk("mid_clr_init_cycles", n, 32);
        chk("mid_clr_init_writes", wr_cnt - base, 32);

        // Reset during a granted write; pointer returns to r0
        acc(0, 1'b1, 5'd7, 2'b11, 2'b00);
        acc(0, 1'b0, 5'd7, 2'b00, 2'b11);
        sb.push_back(mk(1'b0, 2'b11));
        sb.push_back(mk(1'b1, 2'b11));
        run_both(1'b0, 5'd7, 2'b00, 1'b0, 5'd7, 2'b00, 2);
        r1_we = 1'b1; r1_adr = 5'd7; r1_wd = 2'b01; r1_stb = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("mid_acc_wre", int'(ram_wre), 0);
        chk("mid_acc_acks", int'({r1_ack, r0_ack}), 0);
        chk("mid_acc_dat", int'({r1_rd, r0_rd}), 0);
        chk("mid_acc_busy", int'(busy), 1);
        @(posedge clk); #1;
        chk("mid_acc_mem7", int'(mem[7]), 3);
        r1_stb = 1'b0;
        rst = 1'b0;
        count_busy(n);
        chk("mid_acc_init_cycles", n, 32);
        sb.push_back(mk(1'b0, 2'b00));
        sb.push_back(mk(1'b1, 2'b00));
        run_both(1'b1, 5'd10, 2'b10, 1'b1, 5'd11, 2'b01, 2);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dpram_ctl.md
# dpram_ctl

Access controller for the shared `dpram` register store. It zeroes the RAM after reset and on demand, because the RAM's own initialisation is simulation-only. It also arbitrates port A (read/write) between two requesters using a round-robin strobe/acknowledge handshake. It sits between the pipeline's writeback/debug requesters and `dpram` port A; port X stays directly connected to its reader.

## Interface
- `AW`, 5, address width; RAM depth is 2^AW.
- `DW`, 2, data width.

- `clk_i`  in  1  clock; all registers update on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `ena_i`  in  1  global enable; when low, no grant, no clear step.
- `clr_i`  in  1  clear request; sampled in RUN only.
- `busy_o`  out  1  high in INIT or CLR.
- `r0_stb_i`, `r1_stb_i`  in  1  access request; held high until the matching ack.
- `r0_we_i`, `r1_we_i`  in  1  1 = write, 0 = read.
- `r0_adr_i`, `r1_adr_i`  in  AW  address.
- `r0_dat_i`, `r1_dat_i`  in  DW  write data.
- `r0_ack_o`, `r1_ack_o`  out  1  single-cycle completion pulse.
- `r0_dat_o`, `r1_dat_o`  out  DW  registered read data.
- `ram_adr_o`  out  AW  to `dpram` `adr_i`.
- `ram_dat_o`  out  DW  to `dpram` `dat_i`.
- `ram_wre_o`  out  1  to `dpram` `wre_i`; `dpram` `ena_i` is tied to `ena_i`.
- `ram_dat_i`  in  DW  from `dpram` `dat_o` (combinational read).

## Operation
- **FSM states:** INIT, RUN, CLR.
  - Reset → INIT.
  - INIT/CLR → RUN after writing address 2^AW-1.
  - RUN → CLR on `clr_i & ena_i`.
- **Clear sequencing (INIT/CLR):**
  - AW-bit counter `cnt` starts at 0.
  - Each `ena_i` cycle drives `ram_adr_o=cnt`, `ram_dat_o=0`, `ram_wre_o=1`, then increments `cnt`.
  - At `cnt=2^AW-1` the counter wraps to 0 and the FSM exits to RUN.
  - No grants or acks are issued; `clr_i` is ignored.
  - A clear takes exactly 2^AW enabled cycles.
- **Arbitration (RUN):** requester n is eligible when `rn_stb_i & ~rn_ack_o & ena_i`.
  - **One eligible:** it is granted.
  - **Both eligible:** the one named by priority pointer `ptr` is granted, and `ptr` then flips to the other requester.
  - A sole grant leaves `ptr` unchanged.
  - **Port drive:** the grant combinationally drives `ram_adr_o`/`ram_dat_o` from the winner and sets `ram_wre_o = we & grant`.
  - **No grant:** `ram_wre_o=0`; `ram_adr_o`/`ram_dat_o` follow r0.
- **Completion:** at the edge ending a grant cycle, the winner's `ack_o` goes 1 and `dat_o` captures `ram_dat_i`.
  - For a write, `dat_o` holds the pre-write contents.
  - Non-granted `ack_o` registers clear to 0.
  - `dat_o` holds its value until the next grant.
- **`clr_i` collision:** if `clr_i` and a request arrive in the same RUN cycle, the request is still granted that cycle; CLR starts the next cycle.
- **`ena_i`=0:** FSM, `cnt` and `ptr` hold; both acks clear at the next edge; `ram_wre_o=0`.
- **Reset:**
  - Asynchronous `rst_i` mid-clear or mid-access aborts it: state INIT, `cnt=0`, `ptr=0` (r0 first).
  - Outputs: acks 0, `dat_o` 0, `busy_o` 1.
  - `ram_wre_o` is forced 0 while `rst_i` is high.

## Timing
- Access latency: grant in cycle t → ack in cycle t+1, `dat_o` valid with the ack.
- Port A throughput is one access per enabled cycle.
  - A single requester is served at most every other cycle (the `~ack` term).
  - Two contending requesters alternate.
- Port X read data sees a write from cycle t at cycle t+1.
- `busy_o` falls on the edge that writes the last address.
- After reset deassertion: INIT lasts 2^AW enabled cycles (32 at default), and the first possible ack is in the cycle after `busy_o` falls.

## Structure
- Package `dpram_pkg`:
  - State constants `ST_INIT=2'd0`, `ST_RUN=2'd1`, `ST_CLR=2'd2`.
  - Default `AW`/`DW`.
- Sub-module `rr_arb2`: 2-way round-robin arbiter with inputs `req[1:0]`, `ena`, outputs `gnt[1:0]`, and the internal `ptr` register.
- The clear counter, FSM and output muxes stay in `dpram_ctl`.

## Test plan
- **Reset/init:** reset pulse with `ena_i=1` → `busy_o` high 32 cycles, addresses 0..31 written with 0, no acks; RAM contents checked through port X.
- **Single requester:** r0 writes 2'b11 to address 5, then reads 5 → write ack one cycle after grant with `r0_dat_o` = old 0; read ack returns `r0_dat_o=2'b11`.
- **Contention:** both strobes held high for 8 cycles, writing different addresses → acks alternate r0, r1, r0, …; `ptr` flips on every contended grant; no lost writes.
- **Enable stall:** `ena_i` low for 3 cycles during an INIT at `cnt=10` and during a pending request → `cnt`, state and `ptr` frozen; acks 0; `ram_wre_o` 0; resume completes with 32 total writes.
- **Clear collision:** `clr_i` asserted in the same cycle as an r1 write → r1 acked; CLR runs 32 cycles; r0 request during CLR waits, then is acked one cycle after `busy_o` falls.
- **Mid-operation reset:** `rst_i` asserted at `cnt=17` during CLR and during a granted write → immediate INIT, acks 0, `ptr=0`, `ram_wre_o=0` during reset; full 32-cycle INIT restarts from address 0.
